// File: rtl/vptimer_multi_if.sv
// Peripheral register bus shared by the BK timer family: clock-enabled
// read/write strobes, word address, write data and registered read data.
`timescale 1ns/1ps
interface vptimer_multi_if #(
    parameter int ADDR_W = 3
);
    logic              ce;
    logic              regwr;
    logic              regrd;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data_i;
    logic [15:0]       data_o;

    modport master (output ce, regwr, regrd, addr, data_i, input data_o);
    modport slave  (input ce, regwr, regrd, addr, data_i, output data_o);
endinterface

// File: rtl/vptimer_multi.sv
// Multi-channel system timer: CHANNELS down-counters sharing one timebase,
// each with prescale select, one-shot/periodic mode, sticky READY/OVR flags,
// a level interrupt and a one-cycle expiry pulse. PS=11 cascades channel n
// off the expiries of channel n-1 (channel 0 uses the /64 timebase).
`timescale 1ns/1ps
module vptimer_multi #(
    parameter int CHANNELS = 2,
    parameter int WIDTH    = 16,
    parameter int TICKDIV  = 1067,
    parameter int ADDR_W   = 3
) (
    input  logic                clk,
    input  logic                reset,
    vptimer_multi_if.slave      bus,
    output logic [CHANNELS-1:0] irq,
    output logic [CHANNELS-1:0] expire
);

    localparam int               DIV_W    = $clog2(TICKDIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICKDIV - 1);

    typedef enum logic [1:0] {
        REG_RELOAD  = 2'd0,
        REG_COUNTER = 2'd1,
        REG_CTRL    = 2'd2,
        REG_RSVD    = 2'd3
    } reg_e;

    typedef enum logic [1:0] {
        PS_DIV1  = 2'd0,
        PS_DIV4  = 2'd1,
        PS_DIV16 = 2'd2,
        PS_CHAIN = 2'd3
    } ps_e;

    // Field order matches CONTROL[4:0]: PS[4:3], IRQEN[2], ONESHOT[1], RUN[0].
    typedef struct packed {
        ps_e  ps;
        logic irqen;
        logic oneshot;
        logic run;
    } ctrl_t;

    // Timebase
    logic [DIV_W-1:0] div_q;
    logic [5:0]       pre_q;
    logic             tick;
    logic             base64;

    // Per-channel state
    logic [WIDTH-1:0] counter_q [CHANNELS];
    logic [WIDTH-1:0] reload_q  [CHANNELS];
    ctrl_t            ctrl_q    [CHANNELS];
    logic [CHANNELS-1:0] ready_q;
    logic [CHANNELS-1:0] ovr_q;

    // Bus decode and per-channel strobes
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] ch_sel;
    reg_e              reg_sel;
    logic [CHANNELS-1:0] chain_src;
    logic [CHANNELS-1:0] wr_reload;
    logic [CHANNELS-1:0] wr_counter;
    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] rd_stat;
    logic [CHANNELS-1:0] tock;
    logic [CHANNELS-1:0] cnt_en;
    logic [CHANNELS-1:0] expiry;
    logic [15:0]         rd_data;

    // Base tick: one-cycle pulse whenever the divider sits at zero.
    always_comb begin
        tick = (div_q == '0);
    end

    // Free-running divider and 6-bit prescaler; independent of the bus enable.
    // NOTE: every clocked block uses non-blocking assignments so that all
    // registers sample pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            pre_q <= '0;
        end else if (tick) begin
            div_q <= DIV_LAST;
            pre_q <= pre_q + 6'd1;
        end else begin
            div_q <= div_q - DIV_W'(1);
        end
    end

    // Decode bus access and derive per-channel count enables and expiries.
    // NOTE: every output of this block gets a default before any branch,
    // otherwise unassigned paths would infer latches.
    always_comb begin
        wr_en      = bus.ce & bus.regwr;
        rd_en      = bus.ce & bus.regrd & ~bus.regwr;
        ch_sel     = bus.addr >> 2;
        reg_sel    = reg_e'(bus.addr[1:0]);
        base64     = tick & (pre_q == 6'd0);
        // Bit 0 is the /64 timebase for channel 0; bit n is expire[n-1].
        chain_src  = CHANNELS'({expire, base64});
        wr_reload  = '0;
        wr_counter = '0;
        wr_ctrl    = '0;
        rd_stat    = '0;
        tock       = '0;
        cnt_en     = '0;
        expiry     = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                wr_reload[i]  = wr_en & (reg_sel == REG_RELOAD);
                wr_counter[i] = wr_en & (reg_sel == REG_COUNTER);
                wr_ctrl[i]    = wr_en & (reg_sel == REG_CTRL);
                rd_stat[i]    = rd_en & (reg_sel == REG_CTRL);
            end
            case (ctrl_q[i].ps)
                PS_DIV1:  tock[i] = tick;
                PS_DIV4:  tock[i] = tick & (pre_q[1:0] == 2'd0);
                PS_DIV16: tock[i] = tick & (pre_q[3:0] == 4'd0);
                default:  tock[i] = chain_src[i];
            endcase
            // A counter write in the same cycle swallows the tock entirely.
            cnt_en[i] = ctrl_q[i].run & tock[i] & ~wr_counter[i];
            expiry[i] = cnt_en[i] & (counter_q[i] == WIDTH'(1));
        end
    end

    // Register read mux; unmapped channels and the reserved slot read zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == ADDR_W'(i)) begin
                case (reg_sel)
                    REG_RELOAD:  rd_data = 16'(reload_q[i]);
                    REG_COUNTER: rd_data = 16'(counter_q[i]);
                    REG_CTRL:    rd_data = {8'hff, ready_q[i], ovr_q[i], 1'b0, ctrl_q[i]};
                    default:     rd_data = '0;
                endcase
            end
        end
    end

    // Per-channel counters, control, sticky flags, expiry pulse and irq.
    // NOTE: the per-channel arrays are a handful of flops, not RAM, so they
    // take the asynchronous reset like every other register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                counter_q[i] <= '0;
                reload_q[i]  <= '0;
                ctrl_q[i]    <= '0;
            end
            ready_q <= '0;
            ovr_q   <= '0;
            expire  <= '0;
            irq     <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                expire[i] <= expiry[i];
                irq[i]    <= ready_q[i] & ctrl_q[i].irqen;

                if (wr_reload[i]) begin
                    reload_q[i] <= bus.data_i[WIDTH-1:0];
                end

                if (wr_counter[i]) begin
                    counter_q[i] <= bus.data_i[WIDTH-1:0];
                end else if (cnt_en[i]) begin
                    if (counter_q[i] > WIDTH'(1)) begin
                        counter_q[i] <= counter_q[i] - WIDTH'(1);
                    end else begin
                        // Expiry (==1) and idle (==0) both reload in
                        // periodic mode and park at zero in one-shot mode.
                        counter_q[i] <= ctrl_q[i].oneshot ? '0 : reload_q[i];
                    end
                end

                // A same-cycle CONTROL write wins over the one-shot RUN clear.
                if (wr_ctrl[i]) begin
                    ctrl_q[i] <= ctrl_t'(bus.data_i[4:0]);
                end else if (expiry[i] & ctrl_q[i].oneshot) begin
                    ctrl_q[i].run <= 1'b0;
                end

                // Status read clears the flags unless an expiry sets them now.
                ready_q[i] <= expiry[i] | (ready_q[i] & ~rd_stat[i]);
                ovr_q[i]   <= (expiry[i] & ready_q[i]) | (ovr_q[i] & ~rd_stat[i]);
            end
        end
    end

    // Registered read data: updates only on a read access, holds otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_o <= '0;
        end else if (rd_en) begin
            bus.data_o <= rd_data;
        end
    end

endmodule
